shaper_event_sequencer: RTL and testbench

Event sequencer placed after the trapezoidal shaping filter. It watches the shaped pulse stream and triggers on a rising threshold crossing. It then times the rise and flat-top phases and samples the energy at the flat-top midpoint. It flags pile-up from the flat-top spread and presents each event as a timestamped record through a one-entry valid/ready output register.

---
 rtl/shaper_event_sequencer_if.sv | 29 ++
 rtl/shaper_event_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_shaper_event_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shaper_event_sequencer_if.sv
// Event record channel from the shaper event sequencer to its consumer.
// Latency: none; this is a plain bundle of wires.
// Backpressure: consumer holds ev_ready low to keep the record parked in the producer.
interface shaper_event_sequencer_if #(
    parameter int DW   = 16,
    parameter int TS_W = 32
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic signed [DW-1:0] ev_energy;
    logic [TS_W-1:0]      ev_time;
    logic                 ev_pileup;

    modport master (
        output ev_valid,
        output ev_energy,
        output ev_time,
        output ev_pileup,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_energy,
        input  ev_time,
        input  ev_pileup,
        output ev_ready
    );
endinterface

// File: rtl/shaper_event_sequencer.sv
// Triggers on a rising threshold crossing of the shaped stream, times rise and flat-top, samples mid flat-top energy, flags pile-up.
// Latency: record becomes valid K+L cycles after the trigger edge; next trigger no earlier than K+L+HOLDOFF+1 edges after it.
// Backpressure: one-entry output register; a record arriving while it is full and not consumed is dropped and counted.
// Option: define SHAPER_PILEUP_REJECT_EN to discard pile-up records (counted in pu_cnt) instead of flagging them.
module shaper_event_sequencer #(
    parameter int DW      = 16,
    parameter int K       = 100,
    parameter int L       = 200,
    parameter int HOLDOFF = 16,
    parameter int TS_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [DW-1:0]     shp_in,
    input  logic signed [DW-1:0]     thr,
    input  logic        [DW-1:0]     pu_tol,
    shaper_event_sequencer_if.master ev,
    output logic                     busy,
    output logic        [15:0]       drop_cnt,
    output logic        [15:0]       pu_cnt
);
    // One counter times rise, flat-top and holdoff; c is the pre-edge value, so edge E_n sees c = n-1.
    localparam int CW = $clog2(K + L + HOLDOFF + 2);
    localparam logic [CW-1:0] C_RISE_LAST  = CW'(K - 1);
    localparam logic [CW-1:0] C_FLAT_FIRST = CW'(K);
    localparam logic [CW-1:0] C_MID        = CW'(K + L / 2 - 1);
    localparam logic [CW-1:0] C_FLAT_LAST  = CW'(K + L - 1);
    localparam logic [CW-1:0] C_DEAD_LAST  = CW'(K + L + HOLDOFF - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RISE = 3'd2;
    localparam logic [2:0] S_FLAT = 3'd3;
    localparam logic [2:0] S_DEAD = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        c;
    logic [TS_W-1:0]      ts;
    logic [TS_W-1:0]      ts_lat;
    logic                 below_q;
    logic signed [DW-1:0] mn_q;
    logic signed [DW-1:0] mx_q;
    logic signed [DW-1:0] mn_nxt;
    logic signed [DW-1:0] mx_nxt;
    logic signed [DW-1:0] energy_lat;
    logic [DW:0]          spread;
    logic                 pileup_nxt;
    logic                 commit;
    logic                 keep;
    logic                 accept;

    logic                 valid_q;
    logic signed [DW-1:0] energy_q;
    logic [TS_W-1:0]      time_q;
    logic [15:0]          drop_q;

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + TS_W'(1);
    end

    // Remember whether the previous sample was below threshold, in every state.
    always_ff @(posedge clk) begin
        if (rst) below_q <= 1'b0;
        else     below_q <= (shp_in < thr);
    end

    // Running flat-top extremes including the current sample, so the commit edge sample is counted.
    always_comb begin
        mn_nxt = mn_q;
        mx_nxt = mx_q;
        if (c == C_FLAT_FIRST) begin
            mn_nxt = shp_in;
            mx_nxt = shp_in;
        end else begin
            if (shp_in < mn_q) mn_nxt = shp_in;
            if (shp_in > mx_q) mx_nxt = shp_in;
        end
        spread     = {mx_nxt[DW-1], mx_nxt} - {mn_nxt[DW-1], mn_nxt};
        pileup_nxt = (spread > {1'b0, pu_tol});
    end

    assign commit = enable && (state == S_FLAT) && (c == C_FLAT_LAST);
    assign accept = ~valid_q | ev.ev_ready;
`ifdef SHAPER_PILEUP_REJECT_EN
    assign keep   = ~pileup_nxt;
`else
    assign keep   = 1'b1;
`endif

    // Event FSM: arm, trigger on crossing, time rise and flat-top, then hold off before re-arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            c          <= '0;
            ts_lat     <= '0;
            mn_q       <= '0;
            mx_q       <= '0;
            energy_lat <= '0;
        end else if (!enable) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: state <= S_ARM;
                S_ARM: begin
                    if (shp_in >= thr && below_q) begin
                        state  <= S_RISE;
                        c      <= '0;
                        ts_lat <= ts;
                    end
                end
                S_RISE: begin
                    c <= c + CW'(1);
                    if (c == C_RISE_LAST) state <= S_FLAT;
                end
                S_FLAT: begin
                    c    <= c + CW'(1);
                    mn_q <= mn_nxt;
                    mx_q <= mx_nxt;
                    if (c == C_MID)       energy_lat <= shp_in;
                    if (c == C_FLAT_LAST) state <= S_DEAD;
                end
                S_DEAD: begin
                    c <= c + CW'(1);
                    if (c >= C_DEAD_LAST) state <= S_ARM;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: consume on ready, load on commit when free, otherwise count the drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            energy_q <= '0;
            time_q   <= '0;
            drop_q   <= '0;
        end else begin
            if (valid_q && ev.ev_ready) valid_q <= 1'b0;
            if (commit && keep) begin
                if (accept) begin
                    valid_q  <= 1'b1;
                    energy_q <= energy_lat;
                    time_q   <= ts_lat;
                end else if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

`ifdef SHAPER_PILEUP_REJECT_EN
    logic [15:0] pu_q;

    // Count records discarded for pile-up, saturating.
    always_ff @(posedge clk) begin
        if (rst)                                    pu_q <= '0;
        else if (commit && pileup_nxt && pu_q != 16'hFFFF) pu_q <= pu_q + 16'd1;
    end

    assign pu_cnt       = pu_q;
    assign ev.ev_pileup = 1'b0;
`else
    logic pile_q;

    // Pile-up flag travels with the record and is held alongside it.
    always_ff @(posedge clk) begin
        if (rst)                         pile_q <= 1'b0;
        else if (commit && keep && accept) pile_q <= pileup_nxt;
    end

    assign pu_cnt       = 16'd0;
    assign ev.ev_pileup = pile_q;
`endif

    assign ev.ev_valid  = valid_q;
    assign ev.ev_energy = energy_q;
    assign ev.ev_time   = time_q;
    assign drop_cnt     = drop_q;
    assign busy         = (state == S_RISE) || (state == S_FLAT) || (state == S_DEAD);
endmodule

// File: tb/tb_shaper_event_sequencer.sv
// Bench for shaper_event_sequencer: directed scenarios plus a randomized run against an event-level model.
// Latency: one tick per clock; inputs driven 1 time unit after the rising edge.
// Backpressure: ev_ready driven directly by the scenarios.
module tb_shaper_event_sequencer;
    localparam int DW = 16, K = 4, L = 8, HOLDOFF = 2, TS_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b1;
    logic signed [DW-1:0] shp_in = '0;
    logic signed [DW-1:0] thr = 16'sd100;
    logic        [DW-1:0] pu_tol = 16'd5;
    logic                 busy;
    logic [15:0]          drop_cnt;
    logic [15:0]          pu_cnt;

    shaper_event_sequencer_if #(.DW(DW), .TS_W(TS_W)) evif ();

    shaper_event_sequencer #(
        .DW(DW), .K(K), .L(L), .HOLDOFF(HOLDOFF), .TS_W(TS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .shp_in   (shp_in),
        .thr      (thr),
        .pu_tol   (pu_tol),
        .ev       (evif),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .pu_cnt   (pu_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Event-level reference: edges indexed by m_n, events described by trigger edge and offsets from it.
    int m_n = 0, m_ts = 0, m_e0 = 0, m_t0 = 0, m_mn = 0, m_mx = 0, m_en = 0;
    int m_arm_at = 0, m_dead_until = 0;
    bit m_below = 0, m_inflight = 0, m_busy = 0;
    bit m_valid = 0, m_pile = 0;
    int m_energy = 0, m_time = 0, m_drop = 0, m_pu = 0;

    task automatic model_step();
        int s, k;
        bit pre_v, pile;
        s = int'(shp_in);
        m_n++;
        if (rst) begin
            m_ts = 0; m_below = 0; m_inflight = 0; m_arm_at = m_n + 2; m_dead_until = 0;
            m_valid = 0; m_energy = 0; m_time = 0; m_pile = 0; m_drop = 0; m_pu = 0;
        end else begin
            pre_v = m_valid;
            if (m_valid && evif.ev_ready) m_valid = 0;
            if (!enable) begin
                m_inflight = 0; m_dead_until = 0; m_arm_at = m_n + 2;
            end else if (m_inflight) begin
                k = m_n - m_e0;
                if (k == K + L / 2) m_en = s;
                if (k == K + 1) begin
                    m_mn = s; m_mx = s;
                end else if (k > K + 1) begin
                    if (s < m_mn) m_mn = s;
                    if (s > m_mx) m_mx = s;
                end
                if (k == K + L) begin
                    m_inflight = 0; m_dead_until = m_n + HOLDOFF; m_arm_at = m_n + HOLDOFF + 1;
                    pile = ((m_mx - m_mn) > int'(pu_tol));
`ifdef SHAPER_PILEUP_REJECT_EN
                    if (pile) begin
                        if (m_pu < 65535) m_pu++;
                    end else
`endif
                    if (!pre_v || evif.ev_ready) begin
                        m_valid = 1; m_energy = m_en; m_time = m_t0; m_pile = pile;
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                end
            end else if (m_n >= m_arm_at && s >= int'(thr) && m_below) begin
                m_inflight = 1; m_e0 = m_n; m_t0 = m_ts;
            end
            m_below = (s < int'(thr));
            m_ts = (m_ts + 1) % 16;
        end
        m_busy = m_inflight || (m_n < m_dead_until);
    endtask

    task automatic tick(input int s);
        shp_in = 16'(s);
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pval(input int j, input int wob);
        if (j == 0) return 125;
        if (j == 1) return 250;
        if (j == 2) return 375;
        return (wob != 0 && (j % 2) == 1) ? 520 : 500;
    endfunction

    task automatic drive_pulse(input int wob);
        for (int j = 0; j <= K + L; j++) tick(pval(j, wob));
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; evif.ev_ready = 1'b0;
        tick(0); tick(0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; evif.ev_ready = 1'b0;
        tick(0); tick(0);
        checks++; if (evif.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: actual=%b required=0", evif.ev_valid); end
        checks++; if (evif.ev_energy !== 16'sd0) begin failures++; $display("FAIL reset_energy: actual=%0d required=0", evif.ev_energy); end
        checks++; if (evif.ev_time !== 4'd0) begin failures++; $display("FAIL reset_time: actual=%0d required=0", evif.ev_time); end
        checks++; if (evif.ev_pileup !== 1'b0) begin failures++; $display("FAIL reset_pileup: actual=%b required=0", evif.ev_pileup); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: actual=%b required=0", busy); end
        checks++; if (drop_cnt !== 16'd0 || pu_cnt !== 16'd0) begin failures++; $display("FAIL reset_counters: actual drop=%0d pu=%0d required 0/0", drop_cnt, pu_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_clean_pulse();
        int early;
        do_reset();
        tick(0); tick(0); tick(0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clean_busy_before: actual=%b required=0", busy); end
        tick(pval(0, 0));
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clean_busy_after_e0: actual=%b required=1", busy); end
        early = 0;
        for (int j = 1; j < K + L; j++) begin
            tick(pval(j, 0));
            if (evif.ev_valid !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL clean_early_valid: actual=%0d cycles required=0", early); end
        tick(pval(K + L, 0));
        checks++; if (evif.ev_valid !== 1'b1) begin failures++; $display("FAIL clean_valid_at_12: actual=%b required=1", evif.ev_valid); end
        checks++; if (evif.ev_energy !== 16'sd500) begin failures++; $display("FAIL clean_energy: actual=%0d required=500", evif.ev_energy); end
        checks++; if (evif.ev_pileup !== 1'b0) begin failures++; $display("FAIL clean_pileup: actual=%b required=0", evif.ev_pileup); end
        checks++; if (evif.ev_time !== 4'd3) begin failures++; $display("FAIL clean_time: actual=%0d required=3", evif.ev_time); end
        evif.ev_ready = 1'b1;
        tick(0);
        checks++; if (evif.ev_valid !== 1'b0) begin failures++; $display("FAIL clean_consume: actual=%b required=0", evif.ev_valid); end
        evif.ev_ready = 1'b0;
    endtask

    task automatic test_pileup();
        do_reset();
        tick(0); tick(0); tick(0);
        drive_pulse(1);
`ifdef SHAPER_PILEUP_REJECT_EN
        checks++; if (evif.ev_valid !== 1'b0) begin failures++; $display("FAIL pu_reject_valid: actual=%b required=0", evif.ev_valid); end
        checks++; if (pu_cnt !== 16'd1) begin failures++; $display("FAIL pu_reject_cnt: actual=%0d required=1", pu_cnt); end
        checks++; if (evif.ev_pileup !== 1'b0) begin failures++; $display("FAIL pu_reject_flag: actual=%b required=0", evif.ev_pileup); end
`else
        checks++; if (evif.ev_valid !== 1'b1) begin failures++; $display("FAIL pu_valid: actual=%b required=1", evif.ev_valid); end
        checks++; if (evif.ev_pileup !== 1'b1) begin failures++; $display("FAIL pu_flag: actual=%b required=1", evif.ev_pileup); end
        checks++; if (evif.ev_energy !== 16'sd500) begin failures++; $display("FAIL pu_energy: actual=%0d required=500", evif.ev_energy); end
        checks++; if (pu_cnt !== 16'd0) begin failures++; $display("FAIL pu_cnt_zero: actual=%0d required=0", pu_cnt); end
`endif
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL pu_drop: actual=%0d required=0", drop_cnt); end
        tick(0); tick(0); tick(0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            tick(0); tick(0); tick(0);
            drive_pulse(0);
            tick(0); tick(0); tick(0);
        end
        checks++; if (evif.ev_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held: actual=%b required=1", evif.ev_valid); end
        checks++; if (evif.ev_time !== 4'd3 || evif.ev_energy !== 16'sd500) begin failures++; $display("FAIL bp_first_record: actual time=%0d energy=%0d required 3/500", evif.ev_time, evif.ev_energy); end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL bp_drop_cnt: actual=%0d required=2", drop_cnt); end
        evif.ev_ready = 1'b1;
        tick(0);
        evif.ev_ready = 1'b0;
        checks++; if (evif.ev_valid !== 1'b0) begin failures++; $display("FAIL bp_release: actual=%b required=0", evif.ev_valid); end
    endtask

    task automatic test_no_retrigger();
        int stray;
        do_reset();
        evif.ev_ready = 1'b1;
        tick(0); tick(0); tick(0);
        drive_pulse(0);
        checks++; if (evif.ev_valid !== 1'b1) begin failures++; $display("FAIL nr_first_valid: actual=%b required=1", evif.ev_valid); end
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick(500);
            if (i >= 1 && (busy !== 1'b0 || evif.ev_valid !== 1'b0)) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL nr_stray_trigger: actual=%0d cycles required=0", stray); end
        tick(0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nr_busy_low: actual=%b required=0", busy); end
        tick(500);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nr_retrigger: actual=%b required=1", busy); end
        for (int j = 1; j <= K + L; j++) tick(500);
        checks++; if (evif.ev_valid !== 1'b1 || evif.ev_energy !== 16'sd500) begin failures++; $display("FAIL nr_second_record: actual valid=%b energy=%0d required 1/500", evif.ev_valid, evif.ev_energy); end
        evif.ev_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        do_reset();
        evif.ev_ready = 1'b1;
        tick(0); tick(0); tick(0);
        for (int j = 0; j <= 6; j++) tick(pval(j, 0));
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ab_busy_mid: actual=%b required=1", busy); end
        enable = 1'b0;
        tick(pval(7, 0));
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_en_busy: actual=%b required=0", busy); end
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(500);
            if (evif.ev_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL ab_en_no_record: actual=%0d cycles required=0", seen); end

        do_reset();
        for (int p = 0; p < 2; p++) begin
            tick(0); tick(0); tick(0);
            drive_pulse(0);
            tick(0); tick(0); tick(0);
        end
        checks++; if (drop_cnt !== 16'd1 || evif.ev_valid !== 1'b1) begin failures++; $display("FAIL ab_rst_setup: actual drop=%0d valid=%b required 1/1", drop_cnt, evif.ev_valid); end
        for (int j = 0; j <= 6; j++) tick(pval(j, 0));
        rst = 1'b1;
        tick(pval(7, 0));
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || evif.ev_valid !== 1'b0) begin failures++; $display("FAIL ab_rst_state: actual busy=%b valid=%b required 0/0", busy, evif.ev_valid); end
        checks++; if (drop_cnt !== 16'd0 || pu_cnt !== 16'd0) begin failures++; $display("FAIL ab_rst_counters: actual drop=%0d pu=%0d required 0/0", drop_cnt, pu_cnt); end
        checks++; if (evif.ev_time !== 4'd0 || evif.ev_energy !== 16'sd0) begin failures++; $display("FAIL ab_rst_record: actual time=%0d energy=%0d required 0/0", evif.ev_time, evif.ev_energy); end
    endtask

    task automatic test_ts_wrap();
        int targets [3] = '{15, 0, 1};
        int n;
        do_reset();
        evif.ev_ready = 1'b1;
        foreach (targets[t]) begin
            n = 0;
            do begin
                tick(0);
                n++;
            end while ((n < 4 || m_ts != targets[t]) && n < 40);
            checks++; if (m_ts != targets[t]) begin failures++; $display("FAIL ts_align_timeout: actual=%0d required=%0d", m_ts, targets[t]); end
            drive_pulse(0);
            checks++; if (evif.ev_valid !== 1'b1 || evif.ev_time !== 4'(targets[t])) begin failures++; $display("FAIL ts_wrap_time: actual valid=%b time=%0d required 1/%0d", evif.ev_valid, evif.ev_time, targets[t]); end
        end
        tick(0);
        evif.ev_ready = 1'b0;
    endtask

    task automatic test_random();
        int left, mode, amp, s;
        do_reset();
        left = 0; mode = 0; amp = 0;
        for (int i = 0; i < 2500; i++) begin
            if (left == 0) begin
                if (mode == 1) begin mode = 0; left = int'($urandom_range(1, 8)); end
                else begin mode = 1; left = int'($urandom_range(3, 30)); amp = int'($urandom_range(100, 1500)); end
            end
            left--;
            if (mode == 1) s = amp + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : 0);
            else           s = int'($urandom_range(0, 120)) - 20;
            evif.ev_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 99) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick(s);
            checks++; if (evif.ev_valid !== m_valid) begin failures++; if (failures < 20) $display("FAIL rnd_valid cyc=%0d: actual=%b required=%b", i, evif.ev_valid, m_valid); end
            checks++; if (busy !== m_busy) begin failures++; if (failures < 20) $display("FAIL rnd_busy cyc=%0d: actual=%b required=%b", i, busy, m_busy); end
            checks++; if (drop_cnt !== 16'(m_drop) || pu_cnt !== 16'(m_pu)) begin failures++; if (failures < 20) $display("FAIL rnd_counters cyc=%0d: actual drop=%0d pu=%0d required %0d/%0d", i, drop_cnt, pu_cnt, m_drop, m_pu); end
            if (m_valid) begin
                checks++;
                if (evif.ev_energy !== 16'(m_energy) || evif.ev_time !== 4'(m_time) || evif.ev_pileup !== m_pile) begin
                    failures++;
                    if (failures < 20) $display("FAIL rnd_record cyc=%0d: actual e=%0d t=%0d p=%b required e=%0d t=%0d p=%b", i, evif.ev_energy, evif.ev_time, evif.ev_pileup, m_energy, m_time, m_pile);
                end
            end
        end
        rst = 1'b0; enable = 1'b1; evif.ev_ready = 1'b0;
    endtask

    initial begin
        evif.ev_ready = 1'b0;
        test_reset();
        test_clean_pulse();
        test_pileup();
        test_back_to_back();
        test_no_retrigger();
        test_abort();
        test_ts_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
